deserializador_coma: RTL and testbench

//   Receiver half of the paralelo-serial link: shifts in one serial bit per clk, finds
//   8b/10b K28.5 commas, locks 10-bit word alignment and delivers parallel words with a

---
 rtl/deserializador_coma_if.sv | 30 +++
 rtl/deserializador_coma.sv | 133 +++++++++++++
 tb/tb_deserializador_coma.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/deserializador_coma_if.sv
// ============================================================================
// Module  : deserializador_coma_if
// Brief   : Serial-in / parallel-out bundle of the comma-aligned deserializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface deserializador_coma_if;
    logic       enb;
    logic       entrada;
    logic [9:0] salidas;
    logic       valido;
    logic       es_coma;
    logic       alineado;
    logic       realineo;

    // master: the serial line / word consumer side
    modport master (
        output enb, entrada,
        input  salidas, valido, es_coma, alineado, realineo
    );

    // slave: the deserializer itself
    modport slave (
        input  enb, entrada,
        output salidas, valido, es_coma, alineado, realineo
    );
endinterface

`default_nettype wire

// File: rtl/deserializador_coma.sv
// ============================================================================
// Module  : deserializador_coma
// Brief   : Serial-to-10-bit deserializer that locks word alignment on K28.5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializador_coma #(
    parameter logic [9:0]  COMA_A        = 10'h0FA,
    parameter logic [9:0]  COMA_B        = 10'h305,
    parameter int unsigned COMAS_BLOQUEO = 2
) (
    input  wire                         clk,
    input  wire                         rst,
    deserializador_coma_if.slave        bus
);

    typedef enum logic [1:0] {
        c_busca    = 2'd0,
        c_verifica = 2'd1,
        c_alineado = 2'd2
    } t_estado;

    localparam logic [3:0] c_comas = 4'(COMAS_BLOQUEO);
    localparam t_estado    c_tras_coma_fuera =
        (COMAS_BLOQUEO == 1) ? c_alineado : c_verifica;

    t_estado    r_estado;
    logic [8:0] r_sr;
    logic [3:0] r_cnt;
    logic [2:0] r_ccnt;
    logic [9:0] r_salidas;
    logic       r_valido;
    logic       r_es_coma;
    logic       r_realineo;

    t_estado    w_estado_sig;
    logic [3:0] w_cnt_sig;
    logic [2:0] w_ccnt_sig;
    logic       w_entrega;
    logic       w_realinea;

    // Comparisons use the word including the bit being sampled now.
    wire  [9:0] w_nxt      = {r_sr, bus.entrada};
    wire        w_es_c     = (w_nxt == COMA_A) || (w_nxt == COMA_B);
    wire        w_frontera = (r_cnt == 4'd9);
    wire  [3:0] w_ccnt_inc = {1'b0, r_ccnt} + 4'd1;
    wire        w_bloquea  = (w_ccnt_inc >= c_comas);
    wire  [3:0] w_cnt_inc  = w_frontera ? 4'd0 : r_cnt + 4'd1;

    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt;
        w_ccnt_sig   = r_ccnt;
        w_entrega    = 1'b0;
        w_realinea   = 1'b0;
        case (r_estado)
            c_busca: begin
                if (w_es_c) begin
                    w_entrega    = 1'b1;
                    w_cnt_sig    = 4'd0;
                    w_ccnt_sig   = 3'd1;
                    w_estado_sig = c_tras_coma_fuera;
                end
            end
            c_verifica: begin
                w_cnt_sig = w_cnt_inc;
                if (w_frontera) begin
                    w_entrega = 1'b1;
                    if (w_es_c) begin
                        w_ccnt_sig = w_bloquea ? c_comas[2:0] : w_ccnt_inc[2:0];
                        if (w_bloquea)
                            w_estado_sig = c_alineado;
                    end
                end else if (w_es_c) begin
                    w_entrega  = 1'b1;
                    w_realinea = 1'b1;
                    w_cnt_sig  = 4'd0;
                    w_ccnt_sig = 3'd1;
                end
            end
            c_alineado: begin
                w_cnt_sig = w_cnt_inc;
                if (w_frontera) begin
                    w_entrega = 1'b1;
                end else if (w_es_c) begin
                    w_entrega    = 1'b1;
                    w_realinea   = 1'b1;
                    w_cnt_sig    = 4'd0;
                    w_ccnt_sig   = 3'd1;
                    w_estado_sig = c_tras_coma_fuera;
                end
            end
            default: w_estado_sig = c_busca;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado   <= c_busca;
            r_sr       <= 9'd0;
            r_cnt      <= 4'd0;
            r_ccnt     <= 3'd0;
            r_salidas  <= 10'd0;
            r_valido   <= 1'b0;
            r_es_coma  <= 1'b0;
            r_realineo <= 1'b0;
        end else if (bus.enb) begin
            r_estado   <= w_estado_sig;
            r_sr       <= w_nxt[8:0];
            r_cnt      <= w_cnt_sig;
            r_ccnt     <= w_ccnt_sig;
            r_valido   <= w_entrega;
            r_realineo <= w_realinea;
            if (w_entrega) begin
                r_salidas <= w_nxt;
                r_es_coma <= w_es_c;
            end
        end else begin
            r_valido   <= 1'b0;
            r_realineo <= 1'b0;
        end
    end

    assign bus.salidas  = r_salidas;
    assign bus.valido   = r_valido;
    assign bus.es_coma  = r_es_coma;
    assign bus.realineo = r_realineo;
    assign bus.alineado = (r_estado == c_alineado);

endmodule

`default_nettype wire

// File: tb/tb_deserializador_coma.sv
// ============================================================================
// Module  : tb_deserializador_coma
// Brief   : Randomized scoreboard bench for deserializador_coma.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deserializador_coma;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    deserializador_coma_if bus ();

    deserializador_coma #(
        .COMA_A        (10'h0FA),
        .COMA_B        (10'h305),
        .COMAS_BLOQUEO (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0] w;
        logic       c;
        logic       r;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: bits counted since reset, word grid anchored at the last
    // accepted comma, lock when enough consecutive on-grid commas were seen.
    int         win;
    int         t;
    bit         anc;
    int         anchor;
    int         n_ok;
    logic [9:0] exp_sal;
    bit         exp_alin;

    task automatic model_reset();
        win = 0; t = 0; anc = 0; anchor = 0; n_ok = 0;
        exp_sal = 10'd0; exp_alin = 1'b0;
    endtask

    task automatic paso(input bit b, input bit e, input bit r);
        bit comma, deliver, re;
        @(negedge clk);
        bus.entrada = b;
        bus.enb     = e;
        rst         = r;
        if (r) begin
            model_reset();
        end else if (e) begin
            win     = ((win << 1) | int'(b)) & 32'h3FF;
            t       = t + 1;
            comma   = (win == 32'h0FA) || (win == 32'h305);
            deliver = 1'b0;
            re      = 1'b0;
            if (!anc) begin
                if (comma) begin
                    deliver = 1'b1; anc = 1'b1; anchor = t; n_ok = 1;
                end
            end else if ((t - anchor) % 10 == 0) begin
                deliver = 1'b1;
                if (comma && n_ok < N) n_ok = n_ok + 1;
            end else if (comma) begin
                deliver = 1'b1; re = 1'b1; anchor = t; n_ok = 1;
            end
            if (deliver) begin
                q.push_back('{win[9:0], comma, re});
                exp_sal = win[9:0];
            end
            exp_alin = anc && (n_ok >= N);
        end
    endtask

    task automatic send_word(input logic [9:0] w, input int gap_at, input int gap_len);
        for (int i = 9; i >= 0; i--) begin
            if (i == gap_at)
                repeat (gap_len) paso(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            paso(w[i], 1'b1, 1'b0);
        end
    endtask

    // Monitor: pops the scoreboard on every valido, checks levels every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.valido === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_valido salidas=%h expected no word", bus.salidas);
                end else begin
                    e = q.pop_front();
                    if (bus.salidas !== e.w || bus.es_coma !== e.c || bus.realineo !== e.r) begin
                        bad++;
                        $display("FAIL word got salidas=%h es_coma=%b realineo=%b want %h %b %b",
                                 bus.salidas, bus.es_coma, bus.realineo, e.w, e.c, e.r);
                    end
                end
            end else begin
                total++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    bad++;
                    $display("FAIL missing_valido valido=%b want word %h", bus.valido, e.w);
                end
                total++;
                if (bus.realineo !== 1'b0) begin
                    bad++;
                    $display("FAIL realineo_alone realineo=%b want 0", bus.realineo);
                end
            end
            total++;
            if (bus.alineado !== exp_alin) begin
                bad++;
                $display("FAIL alineado got %b want %b", bus.alineado, exp_alin);
            end
            total++;
            if (bus.salidas !== exp_sal) begin
                bad++;
                $display("FAIL salidas_hold got %h want %h", bus.salidas, exp_sal);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.enb     = 1'b1;
        bus.entrada = 1'b0;
        model_reset();

        // reset with toggling data
        for (int i = 0; i < 10; i++) paso(i[0], 1'b1, 1'b1);

        // lock on two commas, then a data word
        send_word(10'h0FA, -1, 0);
        send_word(10'h0FA, -1, 0);
        send_word(10'h36C, -1, 0);

        // misaligned comma forces realignment, relock 10 bits later
        repeat (3) paso(1'b0, 1'b1, 1'b0);
        send_word(10'h305, -1, 0);
        send_word(10'h305, -1, 0);

        // enable gap in the middle of a word
        send_word(10'h1D5, 4, 5);
        send_word(10'h0FA, -1, 0);

        // reset at bit 5 of a word while locked
        for (int i = 9; i >= 5; i--) paso(i[0], 1'b1, 1'b0);
        paso(1'b0, 1'b1, 1'b1);
        send_word(10'h36C, -1, 0);

        // no comma ever: nothing delivered
        paso(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send_word(10'h3FF, -1, 0);
            send_word(10'h000, -1, 0);
            send_word(10'h36C, -1, 0);
        end

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)
                send_word($urandom_range(0, 1) ? 10'h0FA : 10'h305,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1,
                          $urandom_range(1, 4));
            else if (sel < 6)
                send_word(10'($urandom), -1, 0);
            else
                paso(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
                     $urandom_range(0, 149) == 0);
        end

        repeat (3) paso(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover_words got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
